// File: rtl/seg_pkg.sv
// Shared seven-segment definitions: digit count, segment bit order and hex glyphs.
// Cathode byte order is {dp,g,f,e,d,c,b,a}; segment a is bit 0.
package seg_pkg;

  localparam int NUM_DIGITS = 8;
  localparam int SEG_W      = 7;
  localparam int SEG_DP_BIT = 7;

  typedef logic [SEG_W-1:0] seg_t;

  localparam seg_t SEG_0 = 7'h3F;
  localparam seg_t SEG_1 = 7'h06;
  localparam seg_t SEG_2 = 7'h5B;
  localparam seg_t SEG_3 = 7'h4F;
  localparam seg_t SEG_4 = 7'h66;
  localparam seg_t SEG_5 = 7'h6D;
  localparam seg_t SEG_6 = 7'h7D;
  localparam seg_t SEG_7 = 7'h07;
  localparam seg_t SEG_8 = 7'h7F;
  localparam seg_t SEG_9 = 7'h6F;
  localparam seg_t SEG_A = 7'h77;
  localparam seg_t SEG_B = 7'h7C;
  localparam seg_t SEG_C = 7'h39;
  localparam seg_t SEG_D = 7'h5E;
  localparam seg_t SEG_E = 7'h79;
  localparam seg_t SEG_F = 7'h71;

endpackage

// File: rtl/seg7_decode.sv
// Combinational hex-to-seven-segment decoder (segments active-high, a in bit 0).
module seg7_decode
  import seg_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_0;
    case (code)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      default: seg = SEG_F;
    endcase
  end

endmodule

// File: rtl/digit_scan_driver.sv
// Eight-digit multiplexed seven-segment scan driver with per-slot guard time and frame snapshot.
// Optional leading-zero blanking is enabled by defining SEG_LEADING_ZERO_BLANK_EN.
module digit_scan_driver
  import seg_pkg::*;
#(
  parameter int CLK_DIV   = 1000,
  parameter int GUARD_CYC = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [31:0] digit_val,
  input  logic [7:0]  digit_on,
  input  logic [7:0]  dp,
  output logic [7:0]  digit_scan,
  output logic [7:0]  digit_cath
);

  localparam int PW = $clog2(CLK_DIV);

  logic [PW-1:0] presc_q, presc_d;
  logic [2:0]    idx_q, idx_d;
  logic [31:0]   val_q, val_d;
  logic [7:0]    on_q, on_d;
  logic [7:0]    dp_q, dp_d;
  logic [7:0]    scan_q, scan_d;
  logic [7:0]    cath_q, cath_d;

  logic          presc_wrap;
  logic          snap_load;
  logic [3:0]    cur_code;
  logic [6:0]    cur_seg;
  logic [7:0]    on_eff;
  logic          lit;

  assign presc_wrap = (presc_q == PW'(CLK_DIV - 1));
  assign snap_load  = !en || (presc_wrap && idx_q == 3'd7);
  assign cur_code   = val_q[{idx_q, 2'b00} +: 4];

  seg7_decode u_seg7_decode (
    .code (cur_code),
    .seg  (cur_seg)
  );

`ifdef SEG_LEADING_ZERO_BLANK_EN
  logic [7:0] lz_blank;
  logic       higher_zero;

  // A digit is a leading zero when it and every digit above it holds code 0.
  always_comb begin
    lz_blank    = '0;
    higher_zero = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      higher_zero = higher_zero && (val_q[i*4 +: 4] == 4'h0);
      lz_blank[i] = higher_zero;
    end
  end

  assign on_eff = on_q & ~lz_blank;
`else
  assign on_eff = on_q;
`endif

  assign lit = en && (int'(presc_q) >= GUARD_CYC) && on_eff[idx_q];

  always_comb begin
    presc_d = presc_q;
    idx_d   = idx_q;
    val_d   = val_q;
    on_d    = on_q;
    dp_d    = dp_q;
    scan_d  = 8'hFF;
    cath_d  = 8'h00;

    if (!en) begin
      presc_d = '0;
      idx_d   = '0;
    end else if (presc_wrap) begin
      presc_d = '0;
      idx_d   = idx_q + 3'd1;
    end else begin
      presc_d = presc_q + PW'(1);
    end

    // Snapshot only at frame end so a frame never mixes old and new values.
    if (snap_load) begin
      val_d = digit_val;
      on_d  = digit_on;
      dp_d  = dp;
    end

    if (lit) begin
      scan_d                  = ~(8'b1 << idx_q);
      cath_d[SEG_W-1:0]       = cur_seg;
      cath_d[SEG_DP_BIT]      = dp_q[idx_q];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
      idx_q   <= '0;
      val_q   <= '0;
      on_q    <= '0;
      dp_q    <= '0;
      scan_q  <= 8'hFF;
      cath_q  <= 8'h00;
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
      val_q   <= val_d;
      on_q    <= on_d;
      dp_q    <= dp_d;
      scan_q  <= scan_d;
      cath_q  <= cath_d;
    end
  end

  assign digit_scan = scan_q;
  assign digit_cath = cath_q;

endmodule
